// File: rtl/swo_uart_rx_pkg.sv
// Shared constants for the SWO NRZ receiver: FSM state codes, minimum divisor
// and the 3-sample majority voter.
package swo_uart_rx_pkg;

  localparam logic [2:0] SWO_IDLE      = 3'd0;
  localparam logic [2:0] SWO_START     = 3'd1;
  localparam logic [2:0] SWO_DATA      = 3'd2;
  localparam logic [2:0] SWO_STOP      = 3'd3;
  localparam logic [2:0] SWO_WAIT_HIGH = 3'd4;

  localparam int SWO_MIN_DIV = 3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/swo_uart_rx_if.sv
// Receiver-side bus of swo_uart_rx: pin/config inputs and byte/error outputs.
interface swo_uart_rx_if #(
  parameter int pDIV_WIDTH    = 12,
  parameter int pERRCNT_WIDTH = 8
);
  logic                     I_swo;
  logic                     I_enable;
  logic [pDIV_WIDTH-1:0]    I_baud_div;
  logic                     I_clear_errors;
  logic [7:0]               O_data;
  logic                     O_data_valid;
  logic                     O_framing_error;
  logic                     O_break;
  logic                     O_error_sticky;
  logic [pERRCNT_WIDTH-1:0] O_err_count;
  logic                     O_busy;

  modport master (
    output I_swo, I_enable, I_baud_div, I_clear_errors,
    input  O_data, O_data_valid, O_framing_error, O_break,
    input  O_error_sticky, O_err_count, O_busy
  );

  modport slave (
    input  I_swo, I_enable, I_baud_div, I_clear_errors,
    output O_data, O_data_valid, O_framing_error, O_break,
    output O_error_sticky, O_err_count, O_busy
  );
endinterface

// File: rtl/swo_bit_sampler.sv
// Synchronizes the raw SWO pin, runs the bit-period counter and majority-votes
// three mid-bit samples. The counter is held at 0 while the FSM is idle.
module swo_bit_sampler
  import swo_uart_rx_pkg::*;
#(
  parameter int pDIV_WIDTH = 12
) (
  input  logic                  fe_clk,
  input  logic                  reset_i,
  input  logic                  i_swo,
  input  logic                  i_idle,
  input  logic [pDIV_WIDTH-1:0] i_baud_div,
  output logic                  o_fall_edge,
  output logic                  o_line,
  output logic                  o_bit_tick,
  output logic                  o_bit_end,
  output logic                  o_bit_value,
  output logic [pDIV_WIDTH-1:0] o_div
);

  localparam logic [pDIV_WIDTH-1:0] MIN_DIV = pDIV_WIDTH'(SWO_MIN_DIV);
  localparam logic [pDIV_WIDTH-1:0] ONE     = pDIV_WIDTH'(1);

  logic                  r_sync0;
  logic                  r_sync1;
  logic                  r_hist;
  logic [pDIV_WIDTH-1:0] r_div;
  logic [pDIV_WIDTH-1:0] r_cnt;
  logic                  r_s0;
  logic                  r_s1;
  logic [pDIV_WIDTH-1:0] w_half;

  assign w_half = r_div >> 1;

  // Pin synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync0 <= i_swo;
      r_sync1 <= r_sync0;
      r_hist  <= r_sync1;
    end
  end

  // Divisor is captured only while idle so a frame keeps one bit period.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_div <= MIN_DIV;
    end else if (i_idle) begin
      r_div <= (i_baud_div < MIN_DIV) ? MIN_DIV : i_baud_div;
    end else begin
      r_div <= r_div;
    end
  end

  // Bit counter 0..D, plus the two early majority samples.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= {pDIV_WIDTH{1'b0}};
      r_s0  <= 1'b1;
      r_s1  <= 1'b1;
    end else begin
      if (i_idle || (r_cnt == r_div)) begin
        r_cnt <= {pDIV_WIDTH{1'b0}};
      end else begin
        r_cnt <= r_cnt + ONE;
      end
      r_s0 <= (r_cnt == (w_half - ONE)) ? r_sync1 : r_s0;
      r_s1 <= (r_cnt == w_half) ? r_sync1 : r_s1;
    end
  end

  assign o_fall_edge = r_hist & ~r_sync1;
  assign o_line      = r_sync1;
  assign o_bit_tick  = ~i_idle & (r_cnt == (w_half + ONE));
  assign o_bit_end   = ~i_idle & (r_cnt == r_div);
  assign o_bit_value = maj3(r_s0, r_s1, r_sync1);
  assign o_div       = r_div;

endmodule

// File: rtl/swo_uart_rx.sv
// SWO NRZ (8N1) receiver: frame FSM, byte/error strobes and the saturating
// framing-error counter. Bit timing lives in swo_bit_sampler.
module swo_uart_rx
  import swo_uart_rx_pkg::*;
#(
  parameter int pDIV_WIDTH    = 12,
  parameter int pERRCNT_WIDTH = 8
) (
  input logic          fe_clk,
  input logic          reset_i,
  swo_uart_rx_if.slave bus
);

  logic [2:0]               r_state;
  logic [2:0]               w_state_nxt;
  logic [7:0]               r_shift;
  logic [7:0]               w_shift_nxt;
  logic [2:0]               r_bit_idx;
  logic [2:0]               w_bit_idx_nxt;
  logic [pDIV_WIDTH-1:0]    r_hi_cnt;
  logic [pDIV_WIDTH-1:0]    w_hi_cnt_nxt;
  logic                     w_dv;
  logic                     w_fe;
  logic                     w_brk;
  logic [7:0]               r_data;
  logic                     r_dv;
  logic                     r_fe;
  logic                     r_brk;
  logic                     r_busy;
  logic                     r_sticky;
  logic [pERRCNT_WIDTH-1:0] r_err_cnt;

  logic                  w_fall_edge;
  logic                  w_line;
  logic                  w_bit_tick;
  logic                  w_bit_end;
  logic                  w_bit_value;
  logic [pDIV_WIDTH-1:0] w_div;

  swo_bit_sampler #(.pDIV_WIDTH(pDIV_WIDTH)) u_sampler (
    .fe_clk      (fe_clk),
    .reset_i     (reset_i),
    .i_swo       (bus.I_swo),
    .i_idle      (r_state == SWO_IDLE),
    .i_baud_div  (bus.I_baud_div),
    .o_fall_edge (w_fall_edge),
    .o_line      (w_line),
    .o_bit_tick  (w_bit_tick),
    .o_bit_end   (w_bit_end),
    .o_bit_value (w_bit_value),
    .o_div       (w_div)
  );

  // Frame FSM next-state and strobe decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_hi_cnt_nxt  = r_hi_cnt;
    w_dv          = 1'b0;
    w_fe          = 1'b0;
    w_brk         = 1'b0;
    if (!bus.I_enable) begin
      w_state_nxt = SWO_IDLE;
    end else begin
      case (r_state)
        SWO_IDLE: begin
          if (w_fall_edge) w_state_nxt = SWO_START;
          else             w_state_nxt = SWO_IDLE;
        end
        SWO_START: begin
          if (w_bit_tick && w_bit_value) begin
            w_state_nxt = SWO_IDLE;
          end else if (w_bit_end) begin
            w_state_nxt   = SWO_DATA;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_state_nxt = SWO_START;
          end
        end
        SWO_DATA: begin
          if (w_bit_tick) w_shift_nxt = {w_bit_value, r_shift[7:1]};
          else            w_shift_nxt = r_shift;
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) w_state_nxt = SWO_STOP;
            else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
          end else begin
            w_bit_idx_nxt = r_bit_idx;
          end
        end
        SWO_STOP: begin
          if (!w_bit_tick) begin
            w_state_nxt = SWO_STOP;
          end else if (w_bit_value) begin
            w_dv        = 1'b1;
            w_state_nxt = SWO_IDLE;
          end else begin
            w_fe         = 1'b1;
            w_brk        = (r_shift == 8'h00);
            w_hi_cnt_nxt = {pDIV_WIDTH{1'b0}};
            w_state_nxt  = SWO_WAIT_HIGH;
          end
        end
        SWO_WAIT_HIGH: begin
          // Re-arm only after D+1 consecutive high cycles, so a long break
          // yields one strobe.
          if (!w_line)                w_hi_cnt_nxt = {pDIV_WIDTH{1'b0}};
          else if (r_hi_cnt == w_div) w_state_nxt  = SWO_IDLE;
          else                        w_hi_cnt_nxt = r_hi_cnt + pDIV_WIDTH'(1);
        end
        default: w_state_nxt = SWO_IDLE;
      endcase
    end
  end

  // FSM state, shift register and registered outputs.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= SWO_IDLE;
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_hi_cnt  <= {pDIV_WIDTH{1'b0}};
      r_data    <= 8'h00;
      r_dv      <= 1'b0;
      r_fe      <= 1'b0;
      r_brk     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_hi_cnt  <= w_hi_cnt_nxt;
      r_data    <= w_dv ? r_shift : r_data;
      r_dv      <= w_dv;
      r_fe      <= w_fe;
      r_brk     <= w_brk;
      r_busy    <= (w_state_nxt != SWO_IDLE);
    end
  end

  // Error counter and sticky flag; a clear beats a coincident strobe.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_err_cnt <= {pERRCNT_WIDTH{1'b0}};
      r_sticky  <= 1'b0;
    end else if (bus.I_clear_errors) begin
      r_err_cnt <= {pERRCNT_WIDTH{1'b0}};
      r_sticky  <= 1'b0;
    end else if (r_fe) begin
      r_sticky  <= 1'b1;
      r_err_cnt <= (r_err_cnt == {pERRCNT_WIDTH{1'b1}}) ? r_err_cnt
                                                         : r_err_cnt + pERRCNT_WIDTH'(1);
    end else begin
      r_err_cnt <= r_err_cnt;
      r_sticky  <= r_sticky;
    end
  end

  assign bus.O_data          = r_data;
  assign bus.O_data_valid    = r_dv;
  assign bus.O_framing_error = r_fe;
  assign bus.O_break         = r_brk;
  assign bus.O_error_sticky  = r_sticky;
  assign bus.O_err_count     = r_err_cnt;
  assign bus.O_busy          = r_busy;

endmodule

// File: tb/tb_swo_uart_rx.sv
// Self-checking bench for swo_uart_rx: frames are built from 8N1 rules and
// compared against a byte/error-count model kept here.
module tb_swo_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  swo_uart_rx_if #(.pDIV_WIDTH(12), .pERRCNT_WIDTH(8)) bus ();

  swo_uart_rx #(.pDIV_WIDTH(12), .pERRCNT_WIDTH(8)) dut (
    .fe_clk  (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: last good byte and expected error count.
  logic [7:0] exp_data = 8'h00;
  int         exp_errs = 0;

  // Strobe monitor (sole writer of these).
  int         n_dv = 0, n_fe = 0, n_brk = 0, n_viol = 0;
  logic [7:0] q_rx[$];
  logic       p_dv = 1'b0, p_fe = 1'b0, p_brk = 1'b0;

  always @(negedge clk) begin
    if (bus.O_data_valid === 1'b1) begin
      n_dv <= n_dv + 1;
      q_rx.push_back(bus.O_data);
    end
    if (bus.O_framing_error === 1'b1) n_fe <= n_fe + 1;
    if (bus.O_break === 1'b1) n_brk <= n_brk + 1;
    if ((p_dv && bus.O_data_valid) || (p_fe && bus.O_framing_error) ||
        (p_brk && bus.O_break) || (bus.O_data_valid && bus.O_framing_error))
      n_viol <= n_viol + 1;
    p_dv  <= bus.O_data_valid;
    p_fe  <= bus.O_framing_error;
    p_brk <= bus.O_break;
  end

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic drive(input logic v, input int n);
    bus.I_swo = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int div, input logic stop_v);
    int p;
    p = ((div < 3) ? 3 : div) + 1;
    bus.I_baud_div = 12'(div);
    drive(1'b0, p);
    for (int i = 0; i < 8; i++) drive(b[i], p);
    drive(stop_v, p);
    bus.I_swo = 1'b1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.O_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.O_data, bus.O_err_count, bus.O_error_sticky, bus.O_busy,
         bus.O_data_valid, bus.O_framing_error, bus.O_break} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h cnt=%0d sticky=%b busy=%b dv=%b fe=%b brk=%b, required all 0",
               bus.O_data, bus.O_err_count, bus.O_error_sticky, bus.O_busy,
               bus.O_data_valid, bus.O_framing_error, bus.O_break);
    end
  endtask

  task automatic test_byte(input string name, input logic [7:0] b, input int div);
    int dv0, fe0;
    dv0 = n_dv; fe0 = n_fe;
    send_frame(b, div, 1'b1);
    drive(1'b1, 8);
    exp_data = b;
    n_checks++;
    if (n_dv - dv0 != 1 || q_rx[q_rx.size()-1] !== b) begin
      n_fail++;
      $display("FAIL %s: strobes=%0d last=%h, required 1 strobe of %h", name, n_dv - dv0,
               q_rx[q_rx.size()-1], b);
    end
    n_checks++;
    if (bus.O_data !== b || n_fe != fe0 || bus.O_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_hold: data=%h fe=%0d busy=%b, required %h 0 0", name, bus.O_data,
               n_fe - fe0, bus.O_busy, b);
    end
  endtask

  task automatic test_glitch();
    int dv0, fe0;
    bit ok;
    dv0 = n_dv; fe0 = n_fe;
    bus.I_baud_div = 12'd9;
    drive(1'b0, 3);
    bus.I_swo = 1'b1;
    wait_idle(10, ok);
    n_checks++;
    if (!ok || n_dv != dv0 || n_fe != fe0) begin
      n_fail++;
      $display("FAIL glitch: idle_in_10=%b dv=%0d fe=%0d, required 1 0 0", ok, n_dv - dv0, n_fe - fe0);
    end
    drive(1'b1, 12);
    test_byte("after_glitch", 8'h3C, 9);
  endtask

  task automatic test_framing();
    int dv0, fe0;
    bit ok;
    dv0 = n_dv; fe0 = n_fe;
    send_frame(8'h3C, 9, 1'b0);
    wait_idle(40, ok);
    exp_errs = sat_inc(exp_errs);
    n_checks++;
    if (!ok || n_fe - fe0 != 1 || n_dv != dv0) begin
      n_fail++;
      $display("FAIL framing_strobe: idle=%b fe=%0d dv=%0d, required 1 1 0", ok, n_fe - fe0, n_dv - dv0);
    end
    n_checks++;
    if (bus.O_err_count !== 8'(exp_errs) || bus.O_error_sticky !== 1'b1 || bus.O_data !== exp_data) begin
      n_fail++;
      $display("FAIL framing_state: cnt=%0d sticky=%b data=%h, required %0d 1 %h",
               bus.O_err_count, bus.O_error_sticky, bus.O_data, exp_errs, exp_data);
    end
  endtask

  task automatic test_break();
    int fe0, brk0, dv0;
    bit held, ok;
    fe0 = n_fe; brk0 = n_brk; dv0 = n_dv;
    bus.I_baud_div = 12'd9;
    drive(1'b0, 200);
    bus.I_swo = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.O_busy !== 1'b1) held = 1'b0;
    end
    wait_idle(30, ok);
    exp_errs = sat_inc(exp_errs);
    n_checks++;
    if (!held || !ok) begin
      n_fail++;
      $display("FAIL break_rearm: busy_for_10=%b idle_after=%b, required 1 1", held, ok);
    end
    n_checks++;
    if (n_brk - brk0 != 1 || n_fe - fe0 != 1 || n_dv != dv0 || bus.O_err_count !== 8'(exp_errs)) begin
      n_fail++;
      $display("FAIL break_strobes: brk=%0d fe=%0d dv=%0d cnt=%0d, required 1 1 0 %0d",
               n_brk - brk0, n_fe - fe0, n_dv - dv0, bus.O_err_count, exp_errs);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = q_rx.size();
    send_frame(8'h00, 9, 1'b1);
    send_frame(8'hFF, 9, 1'b1);
    drive(1'b1, 10);
    exp_data = 8'hFF;
    n_checks++;
    if (q_rx.size() != base + 2 || q_rx[base] !== 8'h00 || q_rx[base+1] !== 8'hFF) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d bytes, required 2 (00,FF)", q_rx.size() - base);
    end
  endtask

  task automatic test_random();
    logic [7:0] sent[$];
    int base, div;
    logic [7:0] b;
    base = q_rx.size();
    for (int i = 0; i < 8; i++) begin
      div = $urandom_range(3, 12);
      b = 8'($urandom);
      sent.push_back(b);
      send_frame(b, div, 1'b1);
      drive(1'b1, $urandom_range(0, 4));
    end
    drive(1'b1, 12);
    exp_data = sent[sent.size()-1];
    n_checks++;
    if (q_rx.size() != base + sent.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d, required %0d", q_rx.size() - base, sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++) begin
        n_checks++;
        if (q_rx[base+i] !== sent[i]) begin
          n_fail++;
          $display("FAIL random_byte%0d: got %h, required %h", i, q_rx[base+i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_enable_low();
    int dv0, fe0;
    logic busy_seen;
    dv0 = n_dv; fe0 = n_fe;
    busy_seen = 1'b1;
    fork
      send_frame(8'h96, 9, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #2;
        bus.I_enable = 1'b0;
        @(posedge clk);
        #1;
        busy_seen = bus.O_busy;
      end
    join
    drive(1'b1, 10);
    bus.I_enable = 1'b1;
    drive(1'b1, 5);
    n_checks++;
    if (busy_seen !== 1'b0 || n_dv != dv0 || n_fe != fe0 || bus.O_data !== exp_data ||
        bus.O_err_count !== 8'(exp_errs)) begin
      n_fail++;
      $display("FAIL enable_low: busy=%b dv=%0d fe=%0d data=%h cnt=%0d, required 0 0 0 %h %0d",
               busy_seen, n_dv - dv0, n_fe - fe0, bus.O_data, bus.O_err_count, exp_data, exp_errs);
    end
  endtask

  task automatic test_clear_same_cycle();
    bit seen, ok;
    seen = 1'b0;
    fork
      send_frame(8'h55, 9, 1'b0);
      begin
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          if (bus.O_framing_error === 1'b1) begin
            bus.I_clear_errors = 1'b1;
            @(posedge clk);
            #1;
            bus.I_clear_errors = 1'b0;
            seen = 1'b1;
          end
        end
      end
    join
    wait_idle(40, ok);
    exp_errs = 0;
    n_checks++;
    if (!seen || bus.O_err_count !== 8'd0 || bus.O_error_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_same_cycle: strobe=%b cnt=%0d sticky=%b, required 1 0 0",
               seen, bus.O_err_count, bus.O_error_sticky);
    end
  endtask

  task automatic test_reset_midframe();
    fork
      send_frame(8'h5A, 9, 1'b1);
      begin
        repeat (55) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        test_reset();
        #3 rst = 1'b0;
      end
    join
    exp_data = 8'h00;
    drive(1'b1, 150);
    bus.I_clear_errors = 1'b1;
    drive(1'b1, 1);
    bus.I_clear_errors = 1'b0;
    exp_errs = 0;
    test_byte("after_reset", 8'h81, 9);
  endtask

  task automatic test_div_min();
    test_byte("div3", 8'hC3, 3);
    test_byte("div1", 8'hC3, 1);
    test_byte("div1_b", 8'h4E, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.I_swo = 1'b1;
    bus.I_enable = 1'b1;
    bus.I_baud_div = 12'd9;
    bus.I_clear_errors = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    drive(1'b1, 5);
    test_byte("single_A5", 8'hA5, 9);
    test_glitch();
    test_framing();
    test_break();
    test_back_to_back();
    test_random();
    test_enable_low();
    test_clear_same_cycle();
    test_reset_midframe();
    test_div_min();
    n_checks++;
    if (n_viol != 0) begin
      n_fail++;
      $display("FAIL strobe_overlap: %0d violations, required 0", n_viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/swo_uart_rx.md
Name: swo_uart_rx

Overview:
- NRZ (UART-mode) SWO receiver on fe_clk.
- Samples the raw swo pin, recovers 8N1 bytes at a programmable bit rate and presents them as single-cycle strobes.
- Sits directly upstream of trace_top's SWO byte input, replacing the raw swo wire.
- Reports framing errors and line breaks so trace_top can raise O_error_flag.

Parameters:
- pDIV_WIDTH, 12: width of the bit-period divisor.
- pERRCNT_WIDTH, 8: width of the saturating framing-error counter.

Ports:
- fe_clk  input  1  front-end clock; every flop in the block.
- reset_i  input  1  asynchronous, active-high reset.
- I_swo  input  1  raw SWO pin; asynchronous to fe_clk.
- I_enable  input  1  receiver enable; low forces IDLE.
- I_baud_div  input  pDIV_WIDTH  bit period minus 1, in fe_clk cycles; values below 3 are treated as 3.
- I_clear_errors  input  1  synchronous clear of the error counter and sticky flag.
- O_data  output  8  received byte; held until the next valid byte.
- O_data_valid  output  1  one-cycle strobe; O_data is valid in that cycle.
- O_framing_error  output  1  one-cycle strobe on a bad stop bit.
- O_break  output  1  one-cycle strobe on break detection.
- O_error_sticky  output  1  set on any framing error or break; cleared by I_clear_errors.
- O_err_count  output  pERRCNT_WIDTH  saturating count of framing errors, breaks included.
- O_busy  output  1  high while not in IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, synchronizer flops 1 (line idle-high).
- Input path: 2-flop synchronizer, then one history register, giving 3 cycles from pin to edge detect.
- Bit timing:
  - Let D = max(I_baud_div, 3) and C = D>>1.
  - The bit counter runs 0..D, then wraps to 0 and advances the bit index.
  - Three samples are taken at counts C-1, C and C+1; the bit value is their majority.
  - I_baud_div is sampled only in IDLE, so changes mid-frame have no effect.
- States:
  - IDLE:
    - A falling edge on the synchronized line with I_enable=1 loads the counter with 0 and goes to START.
  - START:
    - At count C+1, a majority-high start bit is a glitch: return to IDLE with no strobe.
    - Otherwise continue; at count D go to DATA with bit index 0.
  - DATA:
    - Shift the majority value in LSB-first at C+1.
    - After bit index 7 completes at count D, go to STOP.
  - STOP:
    - Decide at count C+1.
    - Majority high: O_data <= shift register and O_data_valid=1 on the next edge; go to IDLE immediately. The next start edge may arrive in the second half of the stop bit.
    - Majority low with shift register 0x00: O_break=1 and O_framing_error=1 on the next edge; go to WAIT_HIGH.
    - Majority low, any other value: O_framing_error=1 on the next edge; go to WAIT_HIGH.
  - WAIT_HIGH:
    - Stay until the synchronized line has been high for D+1 consecutive cycles, then go to IDLE.
    - A long break therefore produces exactly one O_break.
- Latency: from the stop-bit C+1 sample edge to O_data_valid is 1 cycle.
- Error counter:
  - Increments on each framing-error strobe and saturates at all-ones.
  - If I_clear_errors and an error strobe occur in the same cycle, the clear wins: counter 0, sticky 0.
- I_enable low:
  - Any non-IDLE state returns to IDLE on the next edge.
  - The partial byte is discarded with no strobes.
  - O_data, the counter and the sticky flag hold their values.
- Asynchronous reset mid-frame: every state and output returns to its reset value immediately. The next complete frame is received correctly.
- O_data_valid, O_framing_error and O_break are never high for more than one consecutive cycle.
- O_data_valid and O_framing_error are never high in the same cycle.

Decomposition:
- Shared package (defines_trace.v):
  - state encodings SWO_IDLE, SWO_START, SWO_DATA, SWO_STOP, SWO_WAIT_HIGH;
  - minimum divisor constant SWO_MIN_DIV = 3.
- One natural sub-module, swo_bit_sampler:
  - contains the synchronizer, the bit counter and the 3-sample majority voter;
  - outputs bit_tick, bit_value and fall_edge;
  - the FSM and error logic stay in swo_uart_rx.

Test Plan:
- Single byte: I_baud_div=9, send 0xA5 (8N1, 10 clocks/bit).
  - Required: one O_data_valid pulse with O_data=0xA5, no error strobes, O_busy low after the stop decision.
- Glitch: I_baud_div=9, line low for 3 cycles then high.
  - Required: no strobes, O_busy returns to 0 within 10 cycles, and a following 0x3C is received correctly.
- Framing error: send 0x3C with the stop bit driven low, then the line high.
  - Required: O_framing_error pulse, O_err_count=1, O_error_sticky=1, no O_data_valid, O_data unchanged.
- Break: line low for 20 bit times.
  - Required: exactly one O_break and one O_framing_error, O_err_count +1, and no re-arm until 10 high cycles have passed.
- Back-to-back: send 0x00 then 0xFF with zero idle between frames (stop bit followed immediately by start bit).
  - Required: two valid strobes, carrying 0x00 then 0xFF.
- Clear and reset:
  - I_clear_errors in the same cycle as a framing strobe: count=0 and sticky=0.
  - reset_i pulsed during bit 4 of 0x5A: all outputs 0, and the next 0x81 is received correctly.
  - I_baud_div=1: behaves identically to I_baud_div=3.
